host_link_ctrl: RTL
===================

# host_link_ctrl

Host-side controller for the image downsampling processor. It receives the raw image as a byte stream from the UART receiver and writes it into data memory. It then hands memory to the processor and starts it through the 2-bit status handshake, waits for the processor to return to its end state, and streams the downsampled result back out to the UART transmitter. It sits between the UART pair, the data-memory port mux and the control unit.

## Interface
- IN_LEN, 65536: number of input bytes loaded, at addresses 0..IN_LEN-1
- OUT_BASE, 0: data-memory address of the first result byte
- OUT_LEN, 16384: number of result bytes transmitted
- ADDR_W, 16: data-memory address width
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data this cycle
- dm_addr  out  ADDR_W  data-memory address
- dm_wdata  out  8  write data
- dm_we  out  1  write enable, one cycle per byte
- dm_re  out  1  read enable; dm_rdata valid the following cycle
- dm_rdata  in  8  read data
- mem_sel  out  1  1 = host owns data memory; 0 = processor owns it
- status  out  2  to control unit: 00 idle, 01 start request, 10 running
- proc_end  in  1  1 while the control unit is in its END state
- busy  out  1  1 in any state except IDLE
- done  out  1  one-cycle pulse when the last result byte is accepted
- rx_ovr  out  1  sticky flag: a byte arrived outside LOAD

## Operation
- All outputs are registered.
- Reset values: tx_data=0, tx_valid=0, dm_addr=0, dm_wdata=0, dm_we=0, dm_re=0, mem_sel=1, status=00, busy=0, done=0, rx_ovr=0, cnt=0, state=IDLE.
- IDLE: the first rx_valid clears rx_ovr and cnt, writes that byte at address 0, and moves to LOAD.
- LOAD: each rx_valid produces dm_addr=cnt, dm_wdata=rx_data, dm_we=1 for one cycle, then cnt++.
  - When the byte at IN_LEN-1 is written, go to START with cnt=0.
- START: mem_sel=0, status=01; hold until proc_end=0, then go to RUN.
- RUN: status=10; hold until proc_end=1, then go to RD with status=00 and mem_sel=1.
- RD: dm_addr=OUT_BASE+cnt (modulo 2^ADDR_W), dm_re=1 for one cycle; go to RDW.
- RDW: capture dm_rdata into tx_data, set tx_valid=1; go to SEND.
- SEND: hold tx_data and tx_valid until tx_ready=1.
  - On acceptance, tx_valid drops next cycle.
  - If cnt==OUT_LEN-1: pulse done and go to IDLE.
  - Otherwise cnt++ and go to RD.
- rx_valid in any state other than IDLE/LOAD is discarded and sets rx_ovr. No write occurs.
- cnt width is ADDR_W+1 so IN_LEN=2^ADDR_W does not wrap before termination.

## Timing
- Load: the write is issued the cycle after its rx_valid. Back-to-back rx_valid strobes are supported at one byte per cycle.
- Start handshake: status=01 is visible the cycle after the last load write.
  - RUN is entered the cycle after proc_end is first sampled 0.
  - If proc_end is already 0 on START entry, RUN follows one cycle later.
- Completion: RD is entered the cycle after proc_end is sampled 1 in RUN.
- Read: minimum of 3 cycles per byte (RD, RDW, SEND with tx_ready=1).
  - tx_valid never drops without a handshake.
  - tx_data is stable while tx_valid=1 and tx_ready=0.
- rx_valid and the final tx handshake in the same cycle: the byte is discarded and rx_ovr sets.
- rst_n low mid-operation: all outputs immediately return to reset values (asynchronous). The processor sees status=00. A partial load is not resumed; the next byte starts at address 0.

## Test plan
- Load (IN_LEN=4): bytes 0x11,0x22,0x33,0x44 strobed back-to-back -> writes at addresses 0..3 with matching data, one dm_we each; status=01 and mem_sel=0 the cycle after the last write.
- Start/run: proc_end held 1 for 3 cycles in START, then 0 for 5 cycles, then 1 -> status stays 01 for the first 3 cycles, then 10 during the low period, then 00; mem_sel returns to 1 on completion.
- Readback (OUT_BASE=16, OUT_LEN=2): memory holds 0xA5 at address 16 and 0x5A at address 17, tx_ready tied 1 -> tx_data 0xA5 then 0x5A, each with tx_valid for exactly one cycle; done pulses once; busy=0 afterwards.
- Backpressure: tx_ready held 0 for 10 cycles during the first result byte -> tx_valid and tx_data stay constant for all 10 cycles; no second dm_re is issued.
- Overrun: rx_valid with 0xFF pulsed during RUN -> no dm_we, rx_ovr=1; rx_ovr is cleared by the first byte of the next load.
- Reset mid-load: rst_n low after 2 of 4 bytes -> all outputs at reset values that same cycle; after reset, the next byte is written to address 0.

Source files
------------

// File: rtl/host_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : host_link_ctrl
// Purpose  : Host-side controller for the image downsampling processor.
//            Loads the raw image from the UART receiver into data memory,
//            starts the processor through the 2-bit status handshake, waits
//            for it to finish and streams the result to the UART transmitter.
// Revision : 1.0  initial release
// ============================================================================
module host_link_ctrl #(
    parameter int IN_LEN   = 65536,
    parameter int OUT_BASE = 0,
    parameter int OUT_LEN  = 16384,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [7:0]        dm_wdata,
    output logic              dm_we,
    output logic              dm_re,
    input  logic [7:0]        dm_rdata,
    output logic              mem_sel,
    output logic [1:0]        status,
    input  logic              proc_end,
    output logic              busy,
    output logic              done,
    output logic              rx_ovr
);

    // One extra counter bit so a full 2^ADDR_W load reaches its last index
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  C_IN_LAST   = CNT_W'(IN_LEN - 1);
    localparam logic [CNT_W-1:0]  C_OUT_LAST  = CNT_W'(OUT_LEN - 1);
    localparam logic [ADDR_W-1:0] C_OUT_BASE  = ADDR_W'(OUT_BASE);

    localparam logic [1:0] C_ST_IDLE  = 2'b00;
    localparam logic [1:0] C_ST_START = 2'b01;
    localparam logic [1:0] C_ST_RUN   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_RD    = 3'd4,
        S_RDW   = 3'd5,
        S_SEND  = 3'd6
    } state_t;

    state_t             r_state,    w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,      w_cnt_nxt;
    logic [7:0]         r_tx_data,  w_tx_data_nxt;
    logic               r_tx_valid, w_tx_valid_nxt;
    logic [ADDR_W-1:0]  r_dm_addr,  w_dm_addr_nxt;
    logic [7:0]         r_dm_wdata, w_dm_wdata_nxt;
    logic               r_dm_we,    w_dm_we_nxt;
    logic               r_dm_re,    w_dm_re_nxt;
    logic               r_mem_sel,  w_mem_sel_nxt;
    logic [1:0]         r_status,   w_status_nxt;
    logic               r_busy,     w_busy_nxt;
    logic               r_done,     w_done_nxt;
    logic               r_rx_ovr,   w_rx_ovr_nxt;

    logic [CNT_W-1:0]   w_cnt_inc;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_wdata <= '0;
            r_dm_we    <= 1'b0;
            r_dm_re    <= 1'b0;
            r_mem_sel  <= 1'b1;
            r_status   <= C_ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rx_ovr   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_dm_addr  <= w_dm_addr_nxt;
            r_dm_wdata <= w_dm_wdata_nxt;
            r_dm_we    <= w_dm_we_nxt;
            r_dm_re    <= w_dm_re_nxt;
            r_mem_sel  <= w_mem_sel_nxt;
            r_status   <= w_status_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_rx_ovr   <= w_rx_ovr_nxt;
        end
    end

    // Next-state and next-output decode; the read strobe is raised on the
    // transition into RD so that dm_rdata is valid while in RDW
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_dm_addr_nxt  = r_dm_addr;
        w_dm_wdata_nxt = r_dm_wdata;
        w_dm_we_nxt    = 1'b0;
        w_dm_re_nxt    = 1'b0;
        w_mem_sel_nxt  = r_mem_sel;
        w_status_nxt   = r_status;
        w_done_nxt     = 1'b0;
        w_rx_ovr_nxt   = r_rx_ovr;

        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    w_rx_ovr_nxt   = 1'b0;
                    w_dm_addr_nxt  = '0;
                    w_dm_wdata_nxt = rx_data;
                    w_dm_we_nxt    = 1'b1;
                    if (C_IN_LAST == '0) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_START;
                    end else begin
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (rx_valid) begin
                    w_dm_addr_nxt  = r_cnt[ADDR_W-1:0];
                    w_dm_wdata_nxt = rx_data;
                    w_dm_we_nxt    = 1'b1;
                    if (r_cnt == C_IN_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_START;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
            end
            S_START: begin
                w_mem_sel_nxt = 1'b0;
                w_status_nxt  = C_ST_START;
                if (!proc_end) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_status_nxt = C_ST_RUN;
                if (proc_end) begin
                    w_status_nxt  = C_ST_IDLE;
                    w_mem_sel_nxt = 1'b1;
                    w_dm_re_nxt   = 1'b1;
                    w_dm_addr_nxt = C_OUT_BASE + r_cnt[ADDR_W-1:0];
                    w_state_nxt   = S_RD;
                end
            end
            S_RD: begin
                w_state_nxt = S_RDW;
            end
            S_RDW: begin
                w_tx_data_nxt  = dm_rdata;
                w_tx_valid_nxt = 1'b1;
                w_state_nxt    = S_SEND;
            end
            S_SEND: begin
                if (tx_ready) begin
                    w_tx_valid_nxt = 1'b0;
                    if (r_cnt == C_OUT_LAST) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt     = w_cnt_inc;
                        w_dm_re_nxt   = 1'b1;
                        w_dm_addr_nxt = C_OUT_BASE + w_cnt_inc[ADDR_W-1:0];
                        w_state_nxt   = S_RD;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Bytes arriving while not loading are dropped and flagged
        if (rx_valid && (r_state != S_IDLE) && (r_state != S_LOAD)) begin
            w_rx_ovr_nxt = 1'b1;
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign dm_addr  = r_dm_addr;
    assign dm_wdata = r_dm_wdata;
    assign dm_we    = r_dm_we;
    assign dm_re    = r_dm_re;
    assign mem_sel  = r_mem_sel;
    assign status   = r_status;
    assign busy     = r_busy;
    assign done     = r_done;
    assign rx_ovr   = r_rx_ovr;

endmodule
`default_nettype wire
